// File: rtl/oai211_pipe_bank.sv
// Bank of WIDTH OAI211/AOI211 lanes feeding a STAGES-deep registered pipeline
// with valid tracking, global stall and a full-scan chain through the data flops.

module oai211_lane (
    input  logic mode,
    input  logic a1,
    input  logic a2,
    input  logic b,
    input  logic c,
    output logic zn
);
    always_comb begin
        zn = mode ? ~((a1 & a2) | b | c) : ~((a1 | a2) & b & c);
    end
endmodule

module oai211_pipe_bank #(
    parameter int   WIDTH     = 4,
    parameter int   STAGES    = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             MODE,
    input  logic             VLD_I,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] ZN,
    output logic             VLD_O,
    output logic             SO
);
    localparam int CHAIN = WIDTH * STAGES;

    logic [WIDTH-1:0]             f_res;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0]            vld_pipe_q, vld_pipe_d;
    logic [CHAIN:0]               scan_ext;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        oai211_lane u_lane (
            .mode (MODE),
            .a1   (A1[i]),
            .a2   (A2[i]),
            .b    (B[i]),
            .c    (C[i]),
            .zn   (f_res[i])
        );
    end

    // Packed layout puts stage0 bit0 at the LSB, so one left shift walks the chain.
    always_comb begin
        scan_ext = {data_q, SI};
    end

    always_comb begin
        data_d     = data_q;
        vld_pipe_d = vld_pipe_q;
        if (SE) begin
            data_d = scan_ext[CHAIN-1:0];
        end else if (EN) begin
            data_d[0]     = f_res;
            vld_pipe_d[0] = VLD_I;
            for (int k = 1; k < STAGES; k++) begin
                data_d[k]     = data_q[k-1];
                vld_pipe_d[k] = vld_pipe_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            data_q     <= {CHAIN{RESET_VAL}};
            vld_pipe_q <= '0;
        end else begin
            data_q     <= data_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign ZN    = data_q[STAGES-1];
    assign VLD_O = vld_pipe_q[STAGES-1];
    assign SO    = data_q[STAGES-1][WIDTH-1];
endmodule

// File: tb/tb_oai211_pipe_bank.sv
// Scoreboarded bench: three banks (STAGES=1,2,3) share one stimulus stream; a per-bank
// monitor pops expected results on advancing edges, directed checks cover reset/stall/scan.

module tb_oai211_pipe_bank;
    typedef struct {
        logic [3:0] zn;
        int         cnt;
    } exp_t;

    typedef struct {
        logic       mode;
        logic [3:0] a1, a2, b, c, zn;
    } vec_t;

    logic       clk = 1'b0;
    logic       rn, en, mode, vld_i, se, si;
    logic [3:0] a1, a2, b, c;
    logic [3:0] exp_zn;
    logic [3:0] zn [3];
    logic       vo [3];
    logic       so [3];

    int   checks = 0;
    int   errors = 0;
    int   adv_cnt = 0;
    logic adv_q = 1'b0;
    vec_t vt [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        adv_q <= rn && !se && en;
        if (rn && !se && en) adv_cnt <= adv_cnt + 1;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int S = gi + 1;
        exp_t q [$];

        oai211_pipe_bank #(.WIDTH(4), .STAGES(S), .RESET_VAL(1'b1)) u_dut (
            .CLK   (clk),
            .RN    (rn),
            .EN    (en),
            .MODE  (mode),
            .VLD_I (vld_i),
            .A1    (a1),
            .A2    (a2),
            .B     (b),
            .C     (c),
            .SE    (se),
            .SI    (si),
            .ZN    (zn[gi]),
            .VLD_O (vo[gi]),
            .SO    (so[gi])
        );

        always @(posedge clk) begin
            if (rn && !se && en && vld_i) q.push_back('{zn: exp_zn, cnt: adv_cnt + 1});
        end

        always @(negedge rn) q.delete();

        always @(negedge clk) begin
            exp_t e;
            if (adv_q && rn) begin
                if (vo[gi]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_s%0d: VLD_O=1 ZN=%b, required no output (nothing pending)", S, zn[gi]);
                    end else begin
                        e = q.pop_front();
                        if (zn[gi] !== e.zn || (adv_cnt - e.cnt) != S - 1) begin
                            errors++;
                            $display("FAIL sb_s%0d: ZN=%b latency=%0d, required ZN=%b latency=%0d",
                                     S, zn[gi], adv_cnt - e.cnt, e.zn, S - 1);
                        end
                    end
                end else if (q.size() != 0 && (adv_cnt - q[0].cnt) >= S - 1) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_late_s%0d: VLD_O=0, required VLD_O=1 ZN=%b", S, q[0].zn);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input int i, input logic v);
        mode   = vt[i].mode;
        a1     = vt[i].a1;
        a2     = vt[i].a2;
        b      = vt[i].b;
        c      = vt[i].c;
        exp_zn = vt[i].zn;
        vld_i  = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] seq;
        pat = 8'b10110010;
        seq = 16'b1001_0110_1011_0010;
        // mode, a1, a2, b, c, expected zn (hand-computed)
        vt[0] = '{1'b0, 4'b0011, 4'b0101, 4'b1111, 4'b1110, 4'b1001};
        vt[1] = '{1'b1, 4'b1100, 4'b1010, 4'b0001, 4'b0000, 4'b0110};
        vt[2] = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
        vt[3] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
        vt[4] = '{1'b1, 4'b0101, 4'b0111, 4'b0000, 4'b1000, 4'b0010};
        vt[5] = '{1'b0, 4'b1000, 4'b0001, 4'b1011, 4'b1101, 4'b0110};
        vt[6] = '{1'b1, 4'b0011, 4'b0110, 4'b0100, 4'b0000, 4'b1001};
        vt[7] = '{1'b0, 4'b1010, 4'b0100, 4'b1110, 4'b0111, 4'b1001};

        rn = 1'b1; en = 1'b1; se = 1'b0; si = 1'b0;
        drive(0, 1'b0);
        #1 rn = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_zn", 16'(zn[i]), 16'hF);
            chk("rst_vld", 16'(vo[i]), 16'h0);
            chk("rst_so", 16'(so[i]), 16'h1);
        end
        step();
        rn = 1'b1;

        // streaming with a bubble
        drive(0, 1'b1); step();
        chk("oai_s1_zn", 16'(zn[0]), 16'b1001);
        chk("oai_s1_vld", 16'(vo[0]), 16'h1);
        chk("s3_vld_early", 16'(vo[2]), 16'h0);
        drive(1, 1'b1); step();
        chk("aoi_s1_zn", 16'(zn[0]), 16'b0110);
        chk("s3_vld_early2", 16'(vo[2]), 16'h0);
        drive(2, 1'b0); step();
        chk("s3_zn_v0", 16'(zn[2]), 16'b1001);
        chk("bubble_s1_vld", 16'(vo[0]), 16'h0);
        drive(2, 1'b1); step();
        chk("aoi_s3_zn", 16'(zn[2]), 16'b0110);
        chk("aoi_s3_vld", 16'(vo[2]), 16'h1);
        for (int i = 3; i < 8; i++) begin
            drive(i, 1'b1); step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b0); step();
        end

        // stall with toggling inputs
        drive(5, 1'b1); step();
        drive(6, 1'b1); step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i, 1'b1); step();
            chk("stall_s2_zn", 16'(zn[1]), 16'b0110);
            chk("stall_s2_vld", 16'(vo[1]), 16'h1);
            chk("stall_s1_zn", 16'(zn[0]), 16'b1001);
        end
        en = 1'b1;
        drive(7, 1'b0); step();
        chk("stall_s2_s1out", 16'(zn[1]), 16'b1001);
        chk("stall_s2_s1vld", 16'(vo[1]), 16'h1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0); step();
        end
        chk("drain_s1", 16'(g_dut[0].q.size()), 16'h0);
        chk("drain_s2", 16'(g_dut[1].q.size()), 16'h0);
        chk("drain_s3", 16'(g_dut[2].q.size()), 16'h0);

        // asynchronous reset mid-stream
        drive(1, 1'b1); step();
        drive(2, 1'b1); step();
        chk("pre_rst_vld", 16'(vo[1]), 16'h1);
        #2 rn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_zn", 16'(zn[i]), 16'hF);
            chk("arst_vld", 16'(vo[i]), 16'h0);
            chk("arst_so", 16'(so[i]), 16'h1);
        end
        step();
        rn = 1'b1;

        // scan: load known contents, then shift the pattern through
        drive(0, 1'b1); step();
        drive(1, 1'b1); step();
        se = 1'b1;
        chk("scan_so_0", 16'(so[1]), 16'(seq[15]));
        for (int m = 1; m < 16; m++) begin
            si = (m <= 8) ? pat[8-m] : 1'b0;
            en = (m > 4) ? 1'b0 : 1'b1;
            step();
            chk("scan_so", 16'(so[1]), 16'(seq[15-m]));
        end
        chk("scan_hold_vld_s1", 16'(vo[0]), 16'h1);
        chk("scan_hold_vld_s2", 16'(vo[1]), 16'h1);
        chk("scan_hold_vld_s3", 16'(vo[2]), 16'h0);

        // reset during scan, then resume shifting
        si = 1'b0;
        #2 rn = 1'b0;
        #1;
        chk("scan_rst_zn_s1", 16'(zn[0]), 16'hF);
        chk("scan_rst_zn_s2", 16'(zn[1]), 16'hF);
        chk("scan_rst_so_s2", 16'(so[1]), 16'h1);
        step(); step();
        chk("scan_rst_hold_s1", 16'(zn[0]), 16'hF);
        chk("scan_rst_hold_s2", 16'(zn[1]), 16'hF);
        rn = 1'b1;
        step();
        chk("scan_resume_zn", 16'(zn[0]), 16'b1110);
        chk("scan_resume_so", 16'(so[0]), 16'h1);
        si = 1'b1;
        step();
        chk("scan_resume_zn2", 16'(zn[0]), 16'b1101);
        se = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oai211_pipe_bank.md
Name: oai211_pipe_bank

Overview:
- Parametrised, registered successor to the single-bit OAI211 complex gate.
- WIDTH independent lanes; each lane computes either OAI211, ZN = ~((A1|A2)&B&C), or AOI211, ZN = ~((A1&A2)|B|C), selected per sample.
- The result is carried through a STAGES-deep pipeline with valid tracking, a global stall and a full-scan shift chain.
- Sits in the datapath macro layer as a timing-closed replacement for flat gate arrays plus hand-placed flops.

Parameters:
WIDTH, 4, number of independent lanes (>=1)
STAGES, 1, pipeline depth in register stages (1..4); latency in advancing cycles
RESET_VAL, 1, value loaded into every data bit of every stage on reset (0 or 1)

Ports:
CLK  input  1  rising-edge clock
RN  input  1  asynchronous active-low reset
EN  input  1  advance enable; 0 stalls every stage
MODE  input  1  function select for the sample presented this cycle: 0 = OAI211, 1 = AOI211
VLD_I  input  1  input sample valid
A1  input  WIDTH  lane operand A1
A2  input  WIDTH  lane operand A2
B  input  WIDTH  lane operand B
C  input  WIDTH  lane operand C
SE  input  1  scan enable; overrides EN
SI  input  1  scan data in
ZN  output  WIDTH  last-stage data register
VLD_O  output  1  last-stage valid register
SO  output  1  scan data out = last-stage bit WIDTH-1

Behaviour:
- Reset: is asynchronous. RN=0 immediately forces:
  - every data register to {WIDTH{RESET_VAL}};
  - every valid register to 0.
  - So ZN = {WIDTH{RESET_VAL}}, VLD_O = 0 and SO = RESET_VAL while RN is low, including when reset is asserted mid-operation. In-flight samples are discarded.
- Reset release: the first capture happens on the first CLK rising edge with RN=1. RN deassertion must meet recovery/removal to CLK.
- Function: evaluated combinationally from A1/A2/B/C/MODE ahead of stage 0. MODE is applied per lane and is not registered separately; it travels implicitly with the result.
- Normal advance (SE=0, EN=1), on each rising edge:
  - stage0 data <= f(MODE, inputs); stage0 valid <= VLD_I;
  - stage k <= stage k-1 (data and valid), for k = 1..STAGES-1.
- Data is captured regardless of VLD_I. Only the valid bit qualifies it.
- Latency: a sample presented at edge n appears on ZN/VLD_O after edge n+STAGES-1, counting advancing edges only. With STAGES=1 it is visible right after the capturing edge.
- Stall (SE=0, EN=0): all data and valid registers hold. Inputs are ignored.
- Scan (SE=1), regardless of EN:
  - data registers form one chain of WIDTH*STAGES bits;
  - order: SI -> stage0 bit0 -> stage0 bit1 ... -> stage0 bit WIDTH-1 -> stage1 bit0 ... -> last stage bit WIDTH-1 = SO;
  - shifts one position per rising edge;
  - valid registers hold during scan and are not in the chain.
- Simultaneous events:
  - RN low dominates SE and EN;
  - SE=1 dominates EN and VLD_I.
- Width rules: no arithmetic. All lanes are bitwise independent; lane i uses only bit i of each operand.
- No combinational path from any input to ZN, VLD_O or SO. All outputs are direct register outputs.

Test Plan:
- Reset value: RESET_VAL=1, WIDTH=4, STAGES=2. Assert RN=0 mid-stream with VLD_O=1 -> ZN=4'hF, VLD_O=0 and SO=1 asynchronously, before the next CLK edge.
- OAI211 function: MODE=0, A1=4'b0011, A2=4'b0101, B=4'hF, C=4'b1110, VLD_I=1, EN=1, STAGES=1 -> after one edge ZN=4'b1001, VLD_O=1.
- AOI211 function and latency: MODE=1, A1=4'b1100, A2=4'b1010, B=4'b0001, C=4'b0000, STAGES=3 -> ZN=4'b0110 and VLD_O=1 exactly after the 3rd advancing edge; VLD_O=0 before it.
- Stall: STAGES=2. Present samples S0 and S1, then drop EN for 5 cycles while toggling the inputs -> ZN and VLD_O frozen. On EN=1, S1 emerges at the next edge, unchanged.
- Scan: WIDTH=4, STAGES=2, SE=1, shift SI pattern 8'b10110010 over 8 edges -> SO shows 8 cycles of prior chain contents, then the pattern. The valid registers keep their pre-scan values.
- Priority: SE=1 and EN=0 together -> chain still shifts. RN=0 during SE=1 -> all data = RESET_VAL, shifting stops until RN=1.
